// File: rtl/jahangir_pkg.sv
// Shared types and constants for the fetch-address controller.
// State encoding, default reset PC and an alignment helper.
package jahangir_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STALL   = 2'd2,
    HOLD_BR = 2'd3
  } pc_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  function automatic logic [31:0] align4(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// Redirect/stall bundle between pipeline control and the PC unit.
// master drives requests and observes the fetch address.
interface pc_ctrl_if;
  logic [1:0]  stall_req;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_valid;
  logic [31:0] exc_vector;
  logic [31:0] pc;
  logic        ce;
  logic        flush;
  logic        addr_err;

  modport master (
    output stall_req, br_valid, br_target,
    output exc_valid, exc_vector,
    input  pc, ce, flush, addr_err
  );

  modport slave (
    input  stall_req, br_valid, br_target,
    input  exc_valid, exc_vector,
    output pc, ce, flush, addr_err
  );
endinterface

// File: rtl/pc_ctrl.sv
// Fetch PC controller: reset start, stall hold, branch and
// exception redirects with a one-deep pending branch.
module pc_ctrl
  import jahangir_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  stall_req,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_valid,
  input  logic [31:0] exc_vector,
  output logic [31:0] pc,
  output logic        ce,
  output logic        flush,
  output logic        addr_err
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        flush_q, flush_d;
  logic        aerr_q, aerr_d;
  logic        stall;

  assign stall = |stall_req;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    flush_d = 1'b0;
    aerr_d  = 1'b0;
    if (state_q == IDLE) begin
      state_d = RUN;
    end else if (exc_valid) begin
      pc_d    = align4(exc_vector);
      pend_d  = '0;
      flush_d = 1'b1;
      aerr_d  = |exc_vector[1:0];
      state_d = RUN;
    end else if (br_valid) begin
      aerr_d = |br_target[1:0];
      if (stall) begin
        pend_d  = align4(br_target);
        state_d = HOLD_BR;
      end else begin
        pc_d    = align4(br_target);
        pend_d  = '0;
        state_d = RUN;
      end
    end else if (state_q == HOLD_BR && !stall) begin
      pc_d    = pend_q;
      pend_d  = '0;
      state_d = RUN;
    end else if (stall) begin
      // A pending branch keeps HOLD_BR until the stall clears
      if (state_q != HOLD_BR) state_d = STALL;
    end else begin
      pc_d    = pc_q + 32'd4;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      flush_q <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      flush_q <= flush_d;
      aerr_q  <= aerr_d;
    end
  end

  assign pc       = pc_q;
  assign ce       = (state_q != IDLE);
  assign flush    = flush_q;
  assign addr_err = aerr_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed vector bench for pc_ctrl.
// Table of per-cycle stimulus plus reset corner sequences.
module tb_pc_ctrl;
  import jahangir_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int passed = 0;

  pc_ctrl_if bus();

  pc_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_req  (bus.stall_req),
    .br_valid   (bus.br_valid),
    .br_target  (bus.br_target),
    .exc_valid  (bus.exc_valid),
    .exc_vector (bus.exc_vector),
    .pc         (bus.pc),
    .ce         (bus.ce),
    .flush      (bus.flush),
    .addr_err   (bus.addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic        bv;
    logic [31:0] bt;
    logic        ev;
    logic [31:0] evec;
    logic [31:0] pc;
    logic        fl;
    logic        ae;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [1:0] st, input logic bv,
                     input logic [31:0] bt, input logic ev,
                     input logic [31:0] evec, input logic [31:0] pc,
                     input logic fl, input logic ae);
    vec_t v;
    v.st = st; v.bv = bv; v.bt = bt; v.ev = ev;
    v.evec = evec; v.pc = pc; v.fl = fl; v.ae = ae;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic drive(input logic [1:0] st, input logic bv,
                       input logic [31:0] bt, input logic ev,
                       input logic [31:0] evec);
    bus.stall_req = st;
    bus.br_valid = bv;
    bus.br_target = bt;
    bus.exc_valid = ev;
    bus.exc_vector = evec;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // st bv bt ev evec -> pc after edge, flush, addr_err
    add(2'b00, 0, 0, 0, 0, 32'h0000_0000, 0, 0);
    add(2'b00, 0, 0, 0, 0, 32'h0000_0004, 0, 0);
    add(2'b00, 0, 0, 0, 0, 32'h0000_0008, 0, 0);
    add(2'b00, 0, 0, 0, 0, 32'h0000_000C, 0, 0);
    add(2'b00, 0, 0, 0, 0, 32'h0000_0010, 0, 0);
    add(2'b00, 0, 0, 0, 0, 32'h0000_0014, 0, 0);
    // branch fetched at 0x10 resolves in ID while 0x14 is fetched
    add(2'b00, 1, 32'h100, 0, 0, 32'h0000_0100, 0, 0);
    add(2'b00, 0, 0, 0, 0, 32'h0000_0104, 0, 0);
    add(2'b00, 1, 32'h20, 0, 0, 32'h0000_0020, 0, 0);
    add(2'b10, 1, 32'h200, 0, 0, 32'h0000_0020, 0, 0);
    add(2'b10, 0, 0, 0, 0, 32'h0000_0020, 0, 0);
    add(2'b01, 0, 0, 0, 0, 32'h0000_0020, 0, 0);
    add(2'b00, 0, 0, 0, 0, 32'h0000_0200, 0, 0);
    add(2'b00, 0, 0, 0, 0, 32'h0000_0204, 0, 0);
    add(2'b01, 1, 32'h200, 0, 0, 32'h0000_0204, 0, 0);
    add(2'b01, 0, 0, 0, 0, 32'h0000_0204, 0, 0);
    add(2'b01, 0, 0, 1, 32'h8000_0180, 32'h8000_0180, 1, 0);
    add(2'b00, 0, 0, 0, 0, 32'h8000_0184, 0, 0);
    add(2'b00, 0, 0, 0, 0, 32'h8000_0188, 0, 0);
    add(2'b00, 1, 32'h103, 0, 0, 32'h0000_0100, 0, 1);
    add(2'b00, 0, 0, 0, 0, 32'h0000_0104, 0, 0);
    add(2'b00, 1, 32'h40, 1, 32'h301, 32'h0000_0300, 1, 1);
    add(2'b00, 0, 0, 0, 0, 32'h0000_0304, 0, 0);
    add(2'b10, 1, 32'h400, 0, 0, 32'h0000_0304, 0, 0);
    add(2'b10, 1, 32'h500, 0, 0, 32'h0000_0304, 0, 0);
    add(2'b00, 0, 0, 0, 0, 32'h0000_0500, 0, 0);
    add(2'b01, 0, 0, 0, 0, 32'h0000_0500, 0, 0);
    add(2'b11, 0, 0, 0, 0, 32'h0000_0500, 0, 0);
    add(2'b00, 0, 0, 0, 0, 32'h0000_0504, 0, 0);
    add(2'b00, 1, 32'hFFFF_FFF8, 0, 0, 32'hFFFF_FFF8, 0, 0);
    add(2'b00, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
    add(2'b00, 0, 0, 0, 0, 32'h0000_0000, 0, 0);

    drive(2'b00, 0, 0, 0, 0);
    #12;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_ce", {31'd0, bus.ce}, 32'd0);
    chk("rst_flush", {31'd0, bus.flush}, 32'd0);
    chk("rst_aerr", {31'd0, bus.addr_err}, 32'd0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].st, vq[i].bv, vq[i].bt, vq[i].ev, vq[i].evec);
      tick();
      chk($sformatf("v%0d_pc", i), bus.pc, vq[i].pc);
      chk($sformatf("v%0d_ce", i), {31'd0, bus.ce}, 32'd1);
      chk($sformatf("v%0d_flush", i), {31'd0, bus.flush},
          {31'd0, vq[i].fl});
      chk($sformatf("v%0d_aerr", i), {31'd0, bus.addr_err},
          {31'd0, vq[i].ae});
    end

    // async reset while stalled with a pending branch
    drive(2'b00, 1, 32'h40, 0, 0);
    tick();
    chk("pre_pc", bus.pc, 32'h40);
    drive(2'b01, 1, 32'h600, 0, 0);
    tick();
    drive(2'b01, 0, 0, 0, 0);
    tick();
    chk("hold_pc", bus.pc, 32'h40);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_pc", bus.pc, 32'h0);
    chk("async_ce", {31'd0, bus.ce}, 32'd0);
    drive(2'b00, 1, 32'h700, 1, 32'h703);
    tick();
    tick();
    chk("inrst_pc", bus.pc, 32'h0);
    chk("inrst_fl", {31'd0, bus.flush}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_pc", bus.pc, 32'h0);
    chk("idle_ce", {31'd0, bus.ce}, 32'd1);
    chk("idle_fl", {31'd0, bus.flush}, 32'd0);
    chk("idle_ae", {31'd0, bus.addr_err}, 32'd0);
    drive(2'b00, 0, 0, 0, 0);
    tick();
    chk("post_pc1", bus.pc, 32'h4);
    tick();
    chk("post_pc2", bus.pc, 32'h8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port stall_req, input, 2, hold request: [0] fetch/memory wait, [1] ID hazard; any bit set means stall.
REQ-005 SHALL have port br_valid, input, 1, one-cycle pulse: taken branch/jump resolved in ID.
REQ-006 SHALL have port br_target, input, 32, branch/jump target, sampled only when br_valid=1.
REQ-007 SHALL have port exc_valid, input, 1, one-cycle pulse: exception redirect.
REQ-008 SHALL have port exc_vector, input, 32, exception handler address, sampled only when exc_valid=1.
REQ-009 SHALL have port pc, output, 32, current fetch address.
REQ-010 SHALL have port ce, output, 1, fetch enable; instruction memory reads only when ce=1.
REQ-011 SHALL have port flush, output, 1, one-cycle pulse: kill the instruction in IF/ID.
REQ-012 SHALL have port addr_err, output, 1, one-cycle pulse: misaligned redirect target.

Function
REQ-013 SHALL implement states IDLE, RUN, STALL and HOLD_BR.
REQ-014 IDLE SHALL move to RUN on the first clock after rst_n deasserts; that edge sets ce to 1 and leaves pc at RESET_PC, so RESET_PC is the first address fetched.
REQ-015 In RUN, STALL and HOLD_BR, ce SHALL stay 1.
REQ-016 Per-cycle priority in every non-IDLE state SHALL be exc_valid > br_valid > pending branch > stall > increment.
REQ-017 On exc_valid: pc <= {exc_vector[31:2],2'b00} next edge; flush=1 that cycle; any pending branch discarded; state goes to RUN even if stalled.
REQ-018 On br_valid with no stall: pc <= {br_target[31:2],2'b00} next edge; flush=0 (delay slot already fetched at current pc); state RUN.
REQ-019 On br_valid with stall: target latched into pending register; pc held; state HOLD_BR.
REQ-020 In HOLD_BR with stall still asserted, pc and the pending target SHALL hold; a new br_valid SHALL overwrite the pending target.
REQ-021 In HOLD_BR with stall released, pc <= pending target on that edge; pending cleared; state RUN.
REQ-022 In RUN or STALL with stall asserted and no redirect, pc SHALL hold and state SHALL be STALL; when stall deasserts, state SHALL return to RUN.
REQ-023 In RUN with no event, pc <= pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-024 addr_err SHALL pulse for one cycle in the cycle a redirect is accepted whose source address has bits [1:0] != 0; the redirect still proceeds with the aligned value.
REQ-025 flush and addr_err SHALL be registered outputs and SHALL never be 1 for more than one consecutive cycle per event.

Reset
REQ-026 With rst_n=0, the block SHALL immediately, independent of clk, set pc=RESET_PC, ce=0, flush=0, addr_err=0, pending register=0 and state=IDLE.
REQ-027 Reset asserted mid-redirect or mid-stall SHALL discard all pending state; behaviour after release SHALL be identical to power-up.
REQ-028 In IDLE, all inputs SHALL be ignored.

Structure
REQ-029 The state encoding and the default RESET_PC constant SHALL live in the shared package jahangir_pkg.
REQ-030 pc_ctrl SHALL be a single module; no sub-module is warranted. It replaces the free-running stage1 PC counter.

Verification
REQ-031 Reset release, no stall -> first ce=1 cycle shows pc=0x0; then pc=0x4, 0x8, 0xC on successive cycles.
REQ-032 pc=0x10, br_valid with br_target=0x100, no stall -> pc=0x14 next cycle, then 0x100, 0x104; flush never set.
REQ-033 pc=0x20, stall_req=2'b10 and br_valid with target 0x200 together, stall held 3 cycles -> pc stays 0x20 in HOLD_BR; on release, next pc=0x200.
REQ-034 In HOLD_BR with pending target 0x200, exc_valid with exc_vector=0x8000_0180 -> pc=0x8000_0180, flush=1 for one cycle, 0x200 never fetched.
REQ-035 pc=0xFFFF_FFF8, no events -> 0xFFFF_FFFC, then 0x0000_0000.
REQ-036 br_target=0x103 -> pc=0x100, addr_err=1 for exactly one cycle; separately, rst_n=0 mid-stall -> pc=RESET_PC, ce=0 immediately, without waiting for a clock edge.
